ppa_adder: RTL and testbench
============================

# ppa_adder

16-bit Brent-Kung parallel-prefix adder (module `ppa_adder`) with carry-in and carry-out, followed by one output register stage. It is the adder primitive of the FIR datapath. It adds two unsigned 16-bit operands plus a 1-bit carry-in. The sum and carry-out are registered on the rising clock edge so the adder can sit directly between pipeline stages.

## Interface
- `WIDTH`, default 16: operand width; must be a power of two, 4..64.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: synchronous, active-low reset.
- `add_1`  input  WIDTH: operand A, unsigned.
- `add_2`  input  WIDTH: operand B, unsigned.
- `c_in`  input  1: carry-in.
- `sum`  output  WIDTH: registered low WIDTH bits of `add_1 + add_2 + c_in`.
- `c_out`  output  1: registered carry out of bit WIDTH-1.

## Operation
- Pre-processing, per bit i: `g_i = a_i & b_i`, `p_i = a_i ^ b_i`.
- Carry-in is folded into bit 0 as `g_0' = g_0 | (p_0 & c_in)`.
- Up-sweep prefix tree: log2(WIDTH) levels of (G,P) combine cells at Brent-Kung positions.
  - Level k combines span 2^k.
  - Operator: `(G,P) o (G',P') = (G | P&G', P&P')`.
- Down-sweep: log2(WIDTH)-1 levels fill in the remaining group generates.
- Carries: `c_0 = c_in`; `c_{i+1} = G[i:0]`, including the carry-in term.
- Post-processing: `sum_i = p_i ^ c_i`; `c_out = G[WIDTH-1:0]`.
- The result is mathematically identical to `{c_out,sum} = add_1 + add_2 + c_in`, i.e. a WIDTH+1-bit result.
- Arithmetic wraps modulo 2^WIDTH; the overflow bit appears only on `c_out`. No signed or overflow flag.
- Cells whose P output is unused (the leftmost column feeding carries) are grey cells, G only. All others are black cells.
- No ripple carry chain anywhere.

## Timing
- Prefix logic is combinational from inputs to the register D pins.
- Output register: at each rising `clk`:
  - if `rst_n==0`: `sum <= 0`, `c_out <= 0`;
  - else: `{c_out,sum} <=` the prefix result of the current inputs.
- Latency is 1 cycle: inputs stable before edge N appear on the outputs after edge N. Throughput is one addition per cycle.
- Reset has priority over the data load. Asserting it mid-stream zeroes the outputs at the next edge; the in-flight result is discarded.
- At the first edge after deassertion, the outputs take the current inputs' result.
- Reset values: `sum = 0`, `c_out = 0`.
- Logic depth for WIDTH=16: 1 (g/p) + 7 prefix levels + 1 XOR.
  - Must close at a 5 ns clock period in the target library.
- Outputs are glitch-free: register outputs only.

## Structure
- Shared package `ppa_pkg`:
  - `PPA_WIDTH = 16`;
  - function `ppa_log2` for level counts;
  - typedef for the (G,P) pair.
- Sub-module `bk_prefix_cell`: one (G,P) combine cell. A parameter `GREY` omits the P output.
- Top level contains:
  - a generate loop building the g/p vector;
  - up-sweep and down-sweep generate loops instantiating `bk_prefix_cell`;
  - the sum XOR;
  - the output register.

## Test plan
- Reset: `rst_n=0` for 2 cycles with nonzero inputs -> `sum=0`, `c_out=0`. Release -> next edge shows the input result.
- `add_1=4322`, `add_2=7656`, `c_in=1` -> one cycle later `sum=11979`, `c_out=0`.
- `add_1=987`, `add_2=71`, `c_in=0` -> `sum=1058`, `c_out=0`. Back-to-back with the previous vector, each result appears exactly one cycle after its inputs.
- Full carry propagation:
  - `65534+1`, `c_in=0` -> `sum=65535`, `c_out=0`;
  - same operands with `c_in=1` -> `sum=0`, `c_out=1`.
- Extremes:
  - `65535+65535+1` -> `sum=65535`, `c_out=1`;
  - `0+0+0` -> `sum=0`, `c_out=0`;
  - `0x5555+0xAAAA+1` -> `sum=0`, `c_out=1`.
- Random: 10,000 random operand/carry vectors checked against the `add_1+add_2+c_in` reference model. Include `rst_n` pulses mid-stream; each pulse zeroes the outputs for exactly the reset cycles.

Source files
------------

// File: rtl/ppa_pkg.sv
// ppa_pkg: shared width, level-count helper and (G,P) pair type for the prefix adder.
// Contents: PPA_WIDTH default operand width, ppa_log2() prefix level count, gp_t pair.
package ppa_pkg;

    localparam int PPA_WIDTH = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int ppa_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ppa_adder_if.sv
// ppa_adder_if: operand/result bundle of the prefix adder.
// Signals: add_1, add_2 (operands), c_in (carry-in), sum, c_out (registered result).
// Modports: master drives operands and reads results, slave is the adder side.
interface ppa_adder_if #(
    parameter int WIDTH = ppa_pkg::PPA_WIDTH
);
    logic [WIDTH-1:0] add_1;
    logic [WIDTH-1:0] add_2;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (output add_1, add_2, c_in, input sum, c_out);
    modport slave  (input add_1, add_2, c_in, output sum, c_out);
endinterface

// File: rtl/bk_prefix_cell.sv
// bk_prefix_cell: one (G,P) combine cell, hi o lo = (G | P&G', P&P').
// Ports: hi (more significant group), lo (less significant group), o (combined group).
// GREY=1 marks a cell whose output already spans down to bit 0; its P is never
// consumed, so it is tied low rather than built.
module bk_prefix_cell
    import ppa_pkg::*;
#(
    parameter bit GREY = 1'b0
) (
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);
    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = GREY ? 1'b0 : (hi.p & lo.p);
endmodule

// File: rtl/ppa_adder.sv
// ppa_adder: Brent-Kung parallel-prefix adder with carry-in/out and one output register.
// Ports: clk (rising edge), rst_n (sync, active low), bus (ppa_adder_if.slave:
// add_1, add_2, c_in in; registered sum, c_out out).
module ppa_adder
    import ppa_pkg::*;
#(
    parameter int WIDTH = PPA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    ppa_adder_if.slave        bus
);
    localparam int L  = ppa_log2(WIDTH);
    localparam int NS = 2 * L - 1;

    // n[t][i] is the (G,P) of bit i after prefix stage t; stage 0 is the raw g/p.
    gp_t              n [NS+1][WIDTH];
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    genvar i, k;

    generate
        for (i = 0; i < WIDTH; i++) begin : g_gp
            logic a, b;
            assign a = bus.add_1[i];
            assign b = bus.add_2[i];
            // Carry-in is absorbed into bit 0 so every prefix G[i:0] already includes it.
            if (i == 0) begin : g_lsb
                assign n[0][i].g = (a & b) | ((a ^ b) & bus.c_in);
            end else begin : g_oth
                assign n[0][i].g = a & b;
            end
            assign n[0][i].p = a ^ b;
        end

        // Up-sweep: at level k, bits with (i+1) a multiple of 2^(k+1) absorb the group 2^k below.
        for (k = 0; k < L; k++) begin : g_up
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if ((i + 1) % (2 ** (k + 1)) == 0) begin : g_cell
                    bk_prefix_cell #(.GREY((i + 1) == 2 ** (k + 1))) u_cell (
                        .hi(n[k][i]),
                        .lo(n[k][i - 2 ** k]),
                        .o (n[k + 1][i])
                    );
                end else begin : g_pass
                    assign n[k + 1][i] = n[k][i];
                end
            end
        end

        // Down-sweep: span 2^k from L-2 to 0 fills the gaps from an already complete prefix.
        for (k = L - 2; k >= 0; k--) begin : g_dn
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (((i + 1) % (2 ** (k + 1)) == 2 ** k) && (i >= 2 ** (k + 1))) begin : g_cell
                    bk_prefix_cell #(.GREY(1'b1)) u_cell (
                        .hi(n[2 * L - 2 - k][i]),
                        .lo(n[2 * L - 2 - k][i - 2 ** k]),
                        .o (n[2 * L - 1 - k][i])
                    );
                end else begin : g_pass
                    assign n[2 * L - 1 - k][i] = n[2 * L - 2 - k][i];
                end
            end
        end

        assign c[0] = bus.c_in;
        for (i = 0; i < WIDTH; i++) begin : g_sum
            assign c[i + 1] = n[NS][i].g;
            assign s[i]     = n[0][i].p ^ c[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sum   <= '0;
            bus.c_out <= 1'b0;
        end else begin
            bus.sum   <= s;
            bus.c_out <= c[WIDTH];
        end
    end
endmodule

// File: tb/tb_ppa_adder.sv
// tb_ppa_adder: directed and random checks of the registered 16-bit prefix adder.
module tb_ppa_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ppa_adder_if #(.WIDTH(16)) bus ();

    ppa_adder #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[8] = '{
        '{16'd4322,  16'd7656,  1'b1, {1'b0, 16'd11979}},
        '{16'd987,   16'd71,    1'b0, {1'b0, 16'd1058}},
        '{16'd65534, 16'd1,     1'b0, {1'b0, 16'd65535}},
        '{16'd65534, 16'd1,     1'b1, {1'b1, 16'd0}},
        '{16'd65535, 16'd65535, 1'b1, {1'b1, 16'd65535}},
        '{16'd0,     16'd0,     1'b0, {1'b0, 16'd0}},
        '{16'h5555,  16'hAAAA,  1'b1, {1'b1, 16'd0}},
        '{16'h8000,  16'h8000,  1'b0, {1'b1, 16'd0}}
    };

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got c_out=%0b sum=%0d, expected c_out=%0b sum=%0d",
                     tag, got[16], got[15:0], exp[16], exp[15:0]);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then check the result just after it.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic rn, input logic [16:0] exp);
        @(negedge clk);
        bus.add_1 = a;
        bus.add_2 = b;
        bus.c_in  = ci;
        rst_n     = rn;
        @(posedge clk);
        #1;
        check(tag, {bus.c_out, bus.sum}, exp);
    endtask

    initial begin
        logic [15:0] a, b;
        logic        ci, rn;
        bus.add_1 = 16'd0;
        bus.add_2 = 16'd0;
        bus.c_in  = 1'b0;
        step("reset0", 16'd1234, 16'd4321, 1'b1, 1'b0, 17'd0);
        step("reset1", 16'd1234, 16'd4321, 1'b1, 1'b0, 17'd0);
        step("release", 16'd1234, 16'd4321, 1'b1, 1'b1, {1'b0, 16'd5556});
        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1, vecs[i].exp);
        step("mid_reset", 16'd100, 16'd200, 1'b0, 1'b0, 17'd0);
        step("post_reset", 16'd100, 16'd200, 1'b1, 1'b1, {1'b0, 16'd301});
        for (int n = 0; n < 10000; n++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            rn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            step("random", a, b, ci, rn, rn ? ({1'b0, a} + {1'b0, b} + {16'd0, ci}) : 17'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
